// File: rtl/arb_out_buf.sv
// Output buffer behind an N-way arbiter: captures the granted requester's word
// with its source index into a 2-entry FIFO and presents it on a valid/ready port.
module arb_out_buf #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           arb_req,
  output logic           arb_ack,
  input  logic [N-1:0]   arb_gnt,
  input  logic [N*W-1:0] data_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic [15:0]    out_cnt,
  output logic           gnt_err
);

  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [15:0]   out_cnt_q, out_cnt_d;
  logic          gnt_err_q, gnt_err_d;

  logic [W-1:0]  mem_data_q [2];
  logic [SW-1:0] mem_src_q  [2];

  logic          full;
  logic          push;
  logic          pop;
  logic          gnt_onehot;
  logic [W-1:0]  wr_data;
  logic [SW-1:0] wr_src;

  // Ack depends only on arb_req and registered state so no loop forms through the arbiter.
  assign full      = (count_q == 2'd2);
  assign arb_ack   = arb_req & ~full;
  assign push      = arb_ack;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;

  assign gnt_onehot = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - N'(1))) == '0);

  // AND-OR select: a malformed grant still yields a deterministic word.
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      wr_data = wr_data | (data_i[k*W +: W] & {W{arb_gnt[k]}});
    end
  end

  always_comb begin
    wr_src = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (arb_gnt[k]) begin
        wr_src = SW'(k);
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_cnt_d = out_cnt_q;
    gnt_err_d = gnt_err_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      if (!gnt_onehot) begin
        gnt_err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      out_cnt_q <= 16'd0;
      gnt_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_cnt_q <= out_cnt_d;
      gnt_err_q <= gnt_err_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= wr_data;
      mem_src_q[wr_ptr_q]  <= wr_src;
    end
  end

  assign out_data = mem_data_q[rd_ptr_q];
  assign out_src  = mem_src_q[rd_ptr_q];
  assign out_cnt  = out_cnt_q;
  assign gnt_err  = gnt_err_q;

endmodule

// File: doc/arb_out_buf.md
# arb_out_buf

Output stage placed directly downstream of the N-way arbiters (static, priority, round-robin). It drives the arbiter's upstream acknowledge from its own free space, captures the data word of whichever requester the arbiter granted, and tags it with the source index. The word is held in a 2-entry FIFO and presented on a valid/ready output port. The block decouples the combinational arbiter from downstream backpressure and counts delivered words.

## Interface
- N, 8, number of requesters; must match the arbiter's N
- W, 8, data width per requester
- SW, 3, source-tag width; 2^SW >= N required
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- arb_req  in  1  from arbiter req_o (OR of all requests)
- arb_ack  out  1  to arbiter ack_o; enables grant generation
- arb_gnt  in  N  from arbiter ack_i; one-hot grant vector, valid while arb_ack=1
- data_i  in  N*W  flattened requester data; requester k occupies [k*W+W-1:k*W]
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  W  head data
- out_src  out  SW  head source index
- out_cnt  out  16  number of words popped, wraps modulo 2^16
- gnt_err  out  1  sticky flag for a malformed grant

## Operation
- Storage is 2 entries: {data W, src SW}. 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count (0..2). full = (count==2).
- arb_ack = arb_req & ~full. It is purely combinational from arb_req and registered state. It must never depend on arb_gnt, out_ready or data_i, so that no loop forms through the arbiter.
- Push happens when arb_ack=1 on a clock edge.
  - Written data is the OR over k of (data_i word k AND replicated arb_gnt[k]).
  - Written src is the index of the lowest set bit of arb_gnt.
  - Write pointer toggles.
- Pop happens when out_valid & out_ready on a clock edge. Read pointer toggles and out_cnt increments.
- Count update: push only +1, pop only -1, both unchanged.
- A full FIFO does not accept a push in the same cycle as a pop. arb_ack is already 0 when full, so there is no pass-through.
- Simultaneous push and pop at count==1: the head is popped and the new word is written to the other slot. Count stays 1.
- out_valid = (count!=0). out_data and out_src come from the entry at the read pointer.
- While out_valid=1 and out_ready=0, the head word is held stable.
- gnt_err is set on any push cycle where arb_gnt is zero or has more than one bit set.
  - The malformed word is still written using the rules above (zero grant gives data 0, src 0).
  - gnt_err is cleared only by reset.

## Timing
- Reset (rstn=0, asynchronous) clears count, both pointers, out_cnt and gnt_err. Storage contents are don't-care.
- Output values during and after reset: out_valid=0, gnt_err=0, out_cnt=0, out_data and out_src are X-tolerant don't-care. arb_ack follows arb_req, because the FIFO is not full.
- Push-to-output latency is 1 cycle. A word acked at edge t appears with out_valid=1 after edge t when the FIFO was empty.
- Throughput is 1 word/cycle sustained with out_ready held at 1.
- With out_ready=0, exactly 2 words are accepted, then arb_ack drops the cycle after the second push.
- arb_ack rises again in the cycle after the first pop.
- Reset asserted mid-operation discards all stored words immediately. There is no partial output.
- out_cnt wraps from 0xFFFF to 0x0000 on a pop.

## Test plan
- Reset, then arb_req=1, arb_gnt=8'b0000_0100, requester 2 data=0xA5, out_ready=1 -> arb_ack=1. The next cycle shows out_valid=1, out_data=0xA5, out_src=2, and out_cnt becomes 1 after the pop edge.
- out_ready=0 with three grants to requesters 0, 1, 7 (data 0x11, 0x22, 0x77) -> two pushes, then arb_ack=0. Raising out_ready pops 0x11/src0 then 0x22/src1, and 0x77/src7 is then accepted and delivered.
- Hold arb_req=1 with alternating grants and out_ready=1 for 100 cycles -> 100 words in order, no bubbles after the first, out_cnt=100.
- Push with arb_gnt=8'b0001_0010 -> gnt_err=1 and stays 1. Word src=1, data=OR of requesters 1 and 4. A later valid grant leaves gnt_err=1.
- Fill the FIFO, then assert rstn=0 for 1 cycle mid-stream -> out_valid=0, out_cnt=0, gnt_err=0 immediately, and arb_ack=1 again after release.
- Preload out_cnt to 0xFFFF through 65535 pops, then one more pop -> out_cnt=0x0000.
